hazard_ctrl: RTL and testbench

- Pipeline hazard controller for the 5-stage core.
- Compares the ID-stage source-register probes against the destinations in flight in EX, MEM and WB, and drives the ID-stage forward selects.
- Sequences stage write-enables and flushes for load-use stalls, data-memory wait states and control-flow redirects.
- Keeps saturating stall and flush event counters for performance debug.

---
 rtl/hazard_ctrl.sv | 214 +++++++++++++++++++++
 tb/tb_hazard_ctrl.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: forwarding-select generation, load-use / data-memory-wait
// stall sequencing, control-flow redirect flushes and saturating performance
// counters for the 5-stage core.
//
// Stage handshake: every *_we output is a per-cycle "advance" enable for the
// pipeline register it names. A register captures new contents only on a
// clock edge where its enable is 1. A *_flush output replaces the captured
// contents with a bubble on that same edge. An enable of 0 with no flush
// holds the register's current contents.
module hazard_ctrl #(
  parameter int LOAD_STALL_CYCLES = 1,
  parameter int CNT_W             = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       rs_probe,
  input  logic [4:0]       rt_probe,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic             ex_reg_write,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_dst,
  input  logic             mem_reg_write,
  input  logic [4:0]       mem_dst,
  input  logic             wb_reg_write,
  input  logic [4:0]       wb_dst,
  input  logic             jump_taken,
  input  logic             branch_taken,
  input  logic             dmem_req,
  input  logic             dmem_ack,
  output logic [1:0]       ctrl_rs,
  output logic [1:0]       ctrl_rt,
  output logic             if_we,
  output logic             id_we,
  output logic             ex_we,
  output logic             mem_we,
  output logic             id_flush,
  output logic             ex_flush,
  output logic             mem_flush,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    LOAD_STALL = 2'd1,
    MEM_WAIT   = 2'd2
  } state_e;

  // Bubbles still owed after the current one; LOAD_STALL_CYCLES is 1..7.
  localparam logic [2:0] BUB_INIT = 3'(LOAD_STALL_CYCLES - 1);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_e           state_q, state_d;
  logic [2:0]       bub_q, bub_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic ex_fwd_ok;
  logic mem_wait;
  logic load_use;
  logic stall_pending;
  logic redirect;

  // A load in EX has no data yet, so it can never be the EX forward source.
  assign ex_fwd_ok = ex_reg_write & ~ex_mem_read;

  // Highest-priority in-flight producer of rs: EX, then MEM, then WB.
  always_comb begin
    ctrl_rs = 2'b00;
    if (rs_probe != 5'd0) begin
      if (ex_fwd_ok && (ex_dst == rs_probe)) begin
        ctrl_rs = 2'b01;
      end else if (mem_reg_write && (mem_dst == rs_probe)) begin
        ctrl_rs = 2'b10;
      end else if (wb_reg_write && (wb_dst == rs_probe)) begin
        ctrl_rs = 2'b11;
      end
    end
  end

  // Highest-priority in-flight producer of rt: EX, then MEM, then WB.
  always_comb begin
    ctrl_rt = 2'b00;
    if (rt_probe != 5'd0) begin
      if (ex_fwd_ok && (ex_dst == rt_probe)) begin
        ctrl_rt = 2'b01;
      end else if (mem_reg_write && (mem_dst == rt_probe)) begin
        ctrl_rt = 2'b10;
      end else if (wb_reg_write && (wb_dst == rt_probe)) begin
        ctrl_rt = 2'b11;
      end
    end
  end

  // Hazard conditions seen this cycle.
  always_comb begin
    mem_wait = dmem_req & ~dmem_ack;
    load_use = ex_mem_read & (ex_dst != 5'd0) &
               ((id_uses_rs & (ex_dst == rs_probe)) |
                (id_uses_rt & (ex_dst == rt_probe)));
    // A wait that preempted a load stall leaves its bubble count frozen,
    // so the remaining bubbles resume once the access completes.
    stall_pending = (state_q == LOAD_STALL) ||
                    ((state_q == MEM_WAIT) && (bub_q != 3'd0));
  end

  // Next-state and stage-control decode, memory wait first, then redirects,
  // then load-use bubbles.
  always_comb begin
    state_d   = state_q;
    bub_d     = bub_q;
    if_we     = 1'b1;
    id_we     = 1'b1;
    ex_we     = 1'b1;
    mem_we    = 1'b1;
    id_flush  = 1'b0;
    ex_flush  = 1'b0;
    mem_flush = 1'b0;
    redirect  = 1'b0;

    if (mem_wait) begin
      // Freeze the whole pipe; redirects wait until the access finishes.
      if_we   = 1'b0;
      id_we   = 1'b0;
      ex_we   = 1'b0;
      mem_we  = 1'b0;
      state_d = MEM_WAIT;
    end else if (branch_taken) begin
      id_flush  = 1'b1;
      ex_flush  = 1'b1;
      mem_flush = 1'b1;
      redirect  = 1'b1;
      state_d   = RUN;
      bub_d     = 3'd0;
    end else if (jump_taken) begin
      id_flush = 1'b1;
      ex_flush = 1'b1;
      redirect = 1'b1;
      state_d  = RUN;
      bub_d    = 3'd0;
    end else if (stall_pending) begin
      if_we    = 1'b0;
      id_we    = 1'b0;
      ex_flush = 1'b1;
      if (bub_q > 3'd1) begin
        state_d = LOAD_STALL;
        bub_d   = bub_q - 3'd1;
      end else begin
        state_d = RUN;
        bub_d   = 3'd0;
      end
    end else if (load_use) begin
      if_we    = 1'b0;
      id_we    = 1'b0;
      ex_flush = 1'b1;
      if (BUB_INIT != 3'd0) begin
        state_d = LOAD_STALL;
        bub_d   = BUB_INIT;
      end else begin
        state_d = RUN;
        bub_d   = 3'd0;
      end
    end else begin
      state_d = RUN;
    end

    // Nothing advances or flushes while reset is held.
    if (!reset) begin
      if_we     = 1'b0;
      id_we     = 1'b0;
      ex_we     = 1'b0;
      mem_we    = 1'b0;
      id_flush  = 1'b0;
      ex_flush  = 1'b0;
      mem_flush = 1'b0;
      redirect  = 1'b0;
    end
  end

  // Saturating event counters: frozen fetch cycles and accepted redirects.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (!if_we && (stall_cnt_q != CNT_MAX)) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
    if (redirect && (flush_cnt_q != CNT_MAX)) begin
      flush_cnt_d = flush_cnt_q + 1'b1;
    end
  end

  // State, bubble count and counter registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= RUN;
      bub_q       <= 3'd0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      bub_q       <= bub_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: three instances (1, 3 and 2 load bubbles; the last
// with 4-bit counters so saturation is reachable) share one stimulus stream.
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] rs_probe, rt_probe, ex_dst, mem_dst, wb_dst;
  logic       id_uses_rs, id_uses_rt, ex_reg_write, ex_mem_read;
  logic       mem_reg_write, wb_reg_write, jump_taken, branch_taken;
  logic       dmem_req, dmem_ack;

  logic [1:0]  a_ctrl_rs, a_ctrl_rt, a_dbg;
  logic        a_if_we, a_id_we, a_ex_we, a_mem_we, a_id_flush, a_ex_flush, a_mem_flush;
  logic [15:0] a_stall_cnt, a_flush_cnt;
  logic [1:0]  b_ctrl_rs, b_ctrl_rt, b_dbg;
  logic        b_if_we, b_id_we, b_ex_we, b_mem_we, b_id_flush, b_ex_flush, b_mem_flush;
  logic [15:0] b_stall_cnt, b_flush_cnt;
  logic [1:0]  c_ctrl_rs, c_ctrl_rt, c_dbg;
  logic        c_if_we, c_id_we, c_ex_we, c_mem_we, c_id_flush, c_ex_flush, c_mem_flush;
  logic [3:0]  c_stall_cnt, c_flush_cnt;

  int tests = 0;
  int fails = 0;

  // clock
  always #5 clk = ~clk;

  hazard_ctrl #(.LOAD_STALL_CYCLES(1), .CNT_W(16)) u1 (
    .clk(clk), .reset(reset), .rs_probe(rs_probe), .rt_probe(rt_probe),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .ex_reg_write(ex_reg_write),
    .ex_mem_read(ex_mem_read), .ex_dst(ex_dst), .mem_reg_write(mem_reg_write),
    .mem_dst(mem_dst), .wb_reg_write(wb_reg_write), .wb_dst(wb_dst),
    .jump_taken(jump_taken), .branch_taken(branch_taken), .dmem_req(dmem_req),
    .dmem_ack(dmem_ack), .ctrl_rs(a_ctrl_rs), .ctrl_rt(a_ctrl_rt), .if_we(a_if_we),
    .id_we(a_id_we), .ex_we(a_ex_we), .mem_we(a_mem_we), .id_flush(a_id_flush),
    .ex_flush(a_ex_flush), .mem_flush(a_mem_flush), .stall_cnt(a_stall_cnt),
    .flush_cnt(a_flush_cnt), .dbg_state(a_dbg));

  hazard_ctrl #(.LOAD_STALL_CYCLES(3), .CNT_W(16)) u3 (
    .clk(clk), .reset(reset), .rs_probe(rs_probe), .rt_probe(rt_probe),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .ex_reg_write(ex_reg_write),
    .ex_mem_read(ex_mem_read), .ex_dst(ex_dst), .mem_reg_write(mem_reg_write),
    .mem_dst(mem_dst), .wb_reg_write(wb_reg_write), .wb_dst(wb_dst),
    .jump_taken(jump_taken), .branch_taken(branch_taken), .dmem_req(dmem_req),
    .dmem_ack(dmem_ack), .ctrl_rs(b_ctrl_rs), .ctrl_rt(b_ctrl_rt), .if_we(b_if_we),
    .id_we(b_id_we), .ex_we(b_ex_we), .mem_we(b_mem_we), .id_flush(b_id_flush),
    .ex_flush(b_ex_flush), .mem_flush(b_mem_flush), .stall_cnt(b_stall_cnt),
    .flush_cnt(b_flush_cnt), .dbg_state(b_dbg));

  hazard_ctrl #(.LOAD_STALL_CYCLES(2), .CNT_W(4)) us (
    .clk(clk), .reset(reset), .rs_probe(rs_probe), .rt_probe(rt_probe),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .ex_reg_write(ex_reg_write),
    .ex_mem_read(ex_mem_read), .ex_dst(ex_dst), .mem_reg_write(mem_reg_write),
    .mem_dst(mem_dst), .wb_reg_write(wb_reg_write), .wb_dst(wb_dst),
    .jump_taken(jump_taken), .branch_taken(branch_taken), .dmem_req(dmem_req),
    .dmem_ack(dmem_ack), .ctrl_rs(c_ctrl_rs), .ctrl_rt(c_ctrl_rt), .if_we(c_if_we),
    .id_we(c_id_we), .ex_we(c_ex_we), .mem_we(c_mem_we), .id_flush(c_id_flush),
    .ex_flush(c_ex_flush), .mem_flush(c_mem_flush), .stall_cnt(c_stall_cnt),
    .flush_cnt(c_flush_cnt), .dbg_state(c_dbg));

  // Observed outputs: {rs, rt, if/id/ex/mem we, id/ex/mem flush, stall, flush}
  logic [42:0] obs [3];
  assign obs[0] = {a_ctrl_rs, a_ctrl_rt, a_if_we, a_id_we, a_ex_we, a_mem_we,
                   a_id_flush, a_ex_flush, a_mem_flush, a_stall_cnt, a_flush_cnt};
  assign obs[1] = {b_ctrl_rs, b_ctrl_rt, b_if_we, b_id_we, b_ex_we, b_mem_we,
                   b_id_flush, b_ex_flush, b_mem_flush, b_stall_cnt, b_flush_cnt};
  assign obs[2] = {c_ctrl_rs, c_ctrl_rt, c_if_we, c_id_we, c_ex_we, c_mem_we,
                   c_id_flush, c_ex_flush, c_mem_flush, 12'd0, c_stall_cnt, 12'd0, c_flush_cnt};

  // Reference model: bubbles still owed, and the two event tallies.
  int owed [3] = '{0, 0, 0};
  int scnt [3] = '{0, 0, 0};
  int fcnt [3] = '{0, 0, 0};
  int lsc  [3] = '{1, 3, 2};
  int cmax [3] = '{65535, 65535, 15};

  function automatic logic [1:0] fwd(input logic [4:0] probe);
    logic [4:0] d [3];
    logic       w [3];
    d[0] = ex_dst;  w[0] = ex_reg_write && !ex_mem_read;
    d[1] = mem_dst; w[1] = mem_reg_write;
    d[2] = wb_dst;  w[2] = wb_reg_write;
    if (probe == 5'd0) return 2'd0;
    for (int s = 0; s < 3; s++) begin
      if (w[s] && d[s] == probe) return 2'(s + 1);
    end
    return 2'd0;
  endfunction

  task automatic model_step(input int i, output logic [42:0] e);
    logic [3:0] we;
    logic [2:0] fl;
    bit redirect, mw, lu;
    we = 4'b1111; fl = 3'b000; redirect = 0;
    mw = dmem_req && !dmem_ack;
    lu = ex_mem_read && ex_dst != 0 &&
         ((id_uses_rs && ex_dst == rs_probe) || (id_uses_rt && ex_dst == rt_probe));
    if (!reset) begin
      owed[i] = 0; scnt[i] = 0; fcnt[i] = 0; we = 4'b0000;
    end else if (mw) begin
      we = 4'b0000;
    end else if (branch_taken) begin
      fl = 3'b111; redirect = 1; owed[i] = 0;
    end else if (jump_taken) begin
      fl = 3'b110; redirect = 1; owed[i] = 0;
    end else if (owed[i] > 0) begin
      we = 4'b0011; fl = 3'b010; owed[i]--;
    end else if (lu) begin
      we = 4'b0011; fl = 3'b010; owed[i] = lsc[i] - 1;
    end
    e = {fwd(rs_probe), fwd(rt_probe), we, fl, 16'(scnt[i]), 16'(fcnt[i])};
    if (reset) begin
      if (!we[3] && scnt[i] < cmax[i]) scnt[i]++;
      if (redirect && fcnt[i] < cmax[i]) fcnt[i]++;
    end
  endtask

  // Scoreboard compare, every cycle on the falling edge.
  always @(negedge clk) begin
    logic [42:0] e;
    for (int i = 0; i < 3; i++) begin
      model_step(i, e);
      tests++;
      if (obs[i] !== e) begin
        fails++;
        $display("FAIL cycle_compare dut%0d t=%0t: got %h expected %h", i, $time, obs[i], e);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rs_probe = 0; rt_probe = 0; ex_dst = 0; mem_dst = 0; wb_dst = 0;
    id_uses_rs = 0; id_uses_rt = 0; ex_reg_write = 0; ex_mem_read = 0;
    mem_reg_write = 0; wb_reg_write = 0; jump_taken = 0; branch_taken = 0;
    dmem_req = 0; dmem_ack = 0;
  endtask

  task automatic do_reset();
    cyc(); reset = 1'b0; idle();
    cyc(); reset = 1'b1;
  endtask

  task automatic load_use_rt3();
    idle();
    ex_mem_read = 1; ex_reg_write = 1; ex_dst = 3; rt_probe = 3; id_uses_rt = 1;
  endtask

  initial begin
    reset = 1'b1;
    idle();
    #1 reset = 1'b0;
    #2;
    chk("reset_if_we", 32'(a_if_we), 0);
    chk("reset_mem_we", 32'(b_mem_we), 0);
    chk("reset_flushes", 32'({a_id_flush, a_ex_flush, a_mem_flush}), 0);
    chk("reset_stall_cnt", 32'(a_stall_cnt), 0);
    chk("reset_flush_cnt", 32'(b_flush_cnt), 0);
    chk("reset_state", 32'({a_dbg, b_dbg, c_dbg}), 0);
    cyc(); cyc(); reset = 1'b1;

    // forwarding priority
    cyc();
    ex_dst = 5; mem_dst = 5; wb_dst = 5; rs_probe = 5; id_uses_rs = 1;
    ex_reg_write = 1; mem_reg_write = 1; wb_reg_write = 1;
    #2 chk("fwd_ex", 32'(a_ctrl_rs), 1);
    cyc(); ex_reg_write = 0;
    #2 chk("fwd_mem", 32'(a_ctrl_rs), 2);
    cyc(); ex_reg_write = 1; ex_mem_read = 1;
    #2 chk("fwd_load_skip", 32'(a_ctrl_rs), 2);
    cyc(); ex_mem_read = 0; ex_reg_write = 0; mem_reg_write = 0; rt_probe = 5;
    #2 chk("fwd_wb_rt", 32'(a_ctrl_rt), 3);
    cyc(); rs_probe = 0; ex_reg_write = 1;
    #2 chk("fwd_r0", 32'(a_ctrl_rs), 0);

    // load-use, single and triple bubble
    do_reset();
    cyc(); load_use_rt3();
    #2 chk("lu1_we", 32'({a_if_we, a_id_we, a_ex_flush}), 32'b001);
    chk("lu3_we_c1", 32'(b_if_we), 0);
    cyc(); idle(); rt_probe = 3; id_uses_rt = 1; mem_reg_write = 1; mem_dst = 3;
    #2 chk("lu1_fwd_mem", 32'(a_ctrl_rt), 2);
    chk("lu1_resume", 32'(a_if_we), 1);
    chk("lu1_stall_cnt", 32'(a_stall_cnt), 1);
    chk("lu3_we_c2", 32'({b_if_we, b_id_we, b_ex_flush}), 32'b001);
    cyc();
    #2 chk("lu3_we_c3", 32'(b_if_we), 0);
    cyc(); mem_reg_write = 0; wb_reg_write = 1; wb_dst = 3;
    #2 chk("lu3_resume", 32'(b_if_we), 1);
    chk("lu3_stall_cnt", 32'(b_stall_cnt), 3);
    chk("lu3_fwd_wb", 32'(b_ctrl_rt), 3);

    // branch cancels a multi-cycle stall
    do_reset();
    cyc(); load_use_rt3();
    cyc(); idle(); branch_taken = 1;
    #2 chk("br_cancel_flush", 32'({b_id_flush, b_ex_flush, b_mem_flush}), 32'b111);
    chk("br_cancel_we", 32'({b_if_we, b_id_we, b_ex_we, b_mem_we}), 32'hf);
    cyc(); branch_taken = 0;
    #2 chk("br_cancel_resume", 32'(b_if_we), 1);
    chk("br_cancel_flush_cnt", 32'(b_flush_cnt), 1);
    chk("br_cancel_stall_cnt", 32'(b_stall_cnt), 1);

    // memory wait with an ignored jump
    do_reset();
    for (int k = 0; k < 4; k++) begin
      cyc(); dmem_req = 1; dmem_ack = 0; jump_taken = (k == 1);
      #2 chk("mw_we", 32'({a_if_we, a_id_we, a_ex_we, a_mem_we}), 0);
      chk("mw_flush", 32'({a_id_flush, a_ex_flush, a_mem_flush}), 0);
    end
    cyc(); jump_taken = 0; dmem_ack = 1;
    #2 chk("mw_ack_we", 32'(a_if_we), 1);
    chk("mw_stall_cnt", 32'(a_stall_cnt), 4);
    chk("mw_flush_cnt", 32'(a_flush_cnt), 0);

    // redirects
    do_reset();
    cyc(); branch_taken = 1; jump_taken = 1;
    #2 chk("rd_both", 32'({a_id_flush, a_ex_flush, a_mem_flush}), 32'b111);
    cyc(); branch_taken = 0;
    #2 chk("rd_jump", 32'({a_id_flush, a_ex_flush, a_mem_flush}), 32'b110);
    chk("rd_cnt1", 32'(a_flush_cnt), 1);
    cyc(); idle();
    #2 chk("rd_cnt2", 32'(a_flush_cnt), 2);

    // async reset in the middle of a load stall
    do_reset();
    cyc(); load_use_rt3();
    cyc(); idle();
    #1 chk("ar_in_stall", 32'(b_ex_flush), 1);
    reset = 1'b0;
    #1 chk("ar_outputs", 32'({b_ex_flush, b_ex_we, b_mem_we, b_if_we}), 0);
    chk("ar_stall_cnt", 32'(b_stall_cnt), 0);
    cyc(); reset = 1'b1;
    #2 chk("ar_no_bubble", 32'({b_if_we, b_ex_flush}), 32'b10);
    cyc();
    #2 chk("ar_run", 32'({b_if_we, b_id_we}), 32'b11);
    chk("ar_stall_cnt_after", 32'(b_stall_cnt), 0);

    // counter saturation on the 4-bit instance
    do_reset();
    repeat (20) begin
      cyc(); dmem_req = 1; dmem_ack = 0;
    end
    cyc(); idle();
    #2 chk("sat_stall_cnt", 32'(c_stall_cnt), 15);
    chk("nosat_stall_cnt", 32'(a_stall_cnt), 20);

    // randomized traffic against the model
    for (int n = 0; n < 4000; n++) begin
      cyc();
      reset         = ($urandom_range(0, 299) != 0);
      rs_probe      = 5'($urandom_range(0, 3));
      rt_probe      = 5'($urandom_range(0, 3));
      ex_dst        = 5'($urandom_range(0, 3));
      mem_dst       = 5'($urandom_range(0, 3));
      wb_dst        = 5'($urandom_range(0, 3));
      id_uses_rs    = 1'($urandom_range(0, 1));
      id_uses_rt    = 1'($urandom_range(0, 1));
      ex_reg_write  = 1'($urandom_range(0, 1));
      ex_mem_read   = ($urandom_range(0, 3) == 0);
      mem_reg_write = 1'($urandom_range(0, 1));
      wb_reg_write  = 1'($urandom_range(0, 1));
      jump_taken    = ($urandom_range(0, 15) == 0);
      branch_taken  = ($urandom_range(0, 19) == 0);
      dmem_req      = ($urandom_range(0, 4) == 0);
      dmem_ack      = 1'($urandom_range(0, 1));
    end
    cyc(); idle(); reset = 1'b1;
    cyc();
    #5;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
